// File: rtl/csr_trap_ctrl_pkg.sv
// csr_trap_ctrl_pkg: CSR addresses, write modes, mstatus bits, FSM states and mstatus update helpers
package csr_trap_ctrl_pkg;
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [1:0] WSC_WRITE = 2'b01;
    localparam logic [1:0] WSC_SET   = 2'b10;
    localparam logic [1:0] WSC_CLEAR = 2'b11;
    localparam int MIE  = 3;
    localparam int MPIE = 7;
    typedef enum logic [2:0] {
        IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_VEC, M_STATUS, M_EPC
    } state_e;
    function automatic logic [31:0] mstatus_trap(input logic [31:0] s);
        mstatus_trap = s;
        mstatus_trap[MPIE] = s[MIE];
        mstatus_trap[MIE] = 1'b0;
    endfunction
    function automatic logic [31:0] mstatus_mret(input logic [31:0] s);
        mstatus_mret = s;
        mstatus_mret[MIE] = s[MPIE];
        mstatus_mret[MPIE] = 1'b1;
    endfunction
endpackage

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: owns the CSR file ports, sequencing trap entry / mret and passing pipeline CSR accesses through
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_tval,
    input  logic        mret_req,
    input  logic        pipe_csr_w,
    input  logic [11:0] pipe_csr_waddr,
    input  logic [31:0] pipe_csr_wdata,
    input  logic [1:0]  pipe_csr_mode,
    input  logic [11:0] pipe_csr_raddr,
    input  logic [31:0] csr_rdata,
    input  logic [31:0] mstatus,
    output logic [11:0] csr_raddr,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        csr_w,
    output logic [1:0]  csr_wsc_mode,
    output logic [31:0] pipe_csr_rdata,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    state_e state_q, state_d;
    logic [31:0] cause_q, epc_q, tval_q;
    logic w_en, rv_en;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cause_q <= '0;
            epc_q <= '0;
            tval_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && trap_req) begin
                cause_q <= trap_cause;
                epc_q <= trap_epc;
                tval_q <= trap_tval;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = trap_req ? T_EPC : mret_req ? M_STATUS : IDLE;
            T_EPC:    state_d = T_CAUSE;
            T_CAUSE:  state_d = T_TVAL;
            T_TVAL:   state_d = T_STATUS;
            T_STATUS: state_d = T_VEC;
            M_STATUS: state_d = M_EPC;
            default:  state_d = IDLE;
        endcase
    end
    always_comb begin
        csr_raddr = '0;
        csr_waddr = '0;
        csr_wdata = '0;
        csr_wsc_mode = WSC_WRITE;
        w_en = 1'b0;
        rv_en = 1'b0;
        stall = 1'b1;
        pipe_csr_rdata = '0;
        case (state_q)
            IDLE: begin
                csr_raddr = pipe_csr_raddr;
                csr_waddr = pipe_csr_waddr;
                csr_wdata = pipe_csr_wdata;
                csr_wsc_mode = pipe_csr_mode;
                w_en = pipe_csr_w && !trap_req && !mret_req;
                stall = trap_req || mret_req;
                pipe_csr_rdata = csr_rdata;
            end
            T_EPC: begin
                csr_waddr = ADDR_MEPC;
                csr_wdata = epc_q;
                w_en = 1'b1;
            end
            T_CAUSE: begin
                csr_waddr = ADDR_MCAUSE;
                csr_wdata = cause_q;
                w_en = 1'b1;
            end
            T_TVAL: begin
                csr_waddr = ADDR_MTVAL;
                csr_wdata = tval_q;
                w_en = 1'b1;
            end
            T_STATUS: begin
                csr_waddr = ADDR_MSTATUS;
                csr_wdata = mstatus_trap(mstatus);
                w_en = 1'b1;
            end
            T_VEC: begin
                csr_raddr = ADDR_MTVEC;
                rv_en = 1'b1;
            end
            M_STATUS: begin
                csr_waddr = ADDR_MSTATUS;
                csr_wdata = mstatus_mret(mstatus);
                w_en = 1'b1;
            end
            M_EPC: begin
                csr_raddr = ADDR_MEPC;
                rv_en = 1'b1;
            end
            default: ;
        endcase
    end
    // reset takes effect on the ports immediately so an aborted sequence writes nothing more
    assign csr_w = w_en && !rst;
    assign redirect_valid = rv_en && !rst;
    assign redirect_pc = redirect_valid ? {csr_rdata[31:2], 2'b00} : '0;
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: directed scoreboard bench for csr_trap_ctrl
module tb_csr_trap_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_req = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_epc = '0;
    logic [31:0] trap_tval = '0;
    logic        mret_req = 1'b0;
    logic        pipe_csr_w = 1'b0;
    logic [11:0] pipe_csr_waddr = '0;
    logic [31:0] pipe_csr_wdata = '0;
    logic [1:0]  pipe_csr_mode = 2'b01;
    logic [11:0] pipe_csr_raddr = 12'h305;
    logic [31:0] csr_rdata;
    logic [31:0] mstatus = '0;
    logic [11:0] csr_raddr, csr_waddr;
    logic [31:0] csr_wdata, pipe_csr_rdata, redirect_pc;
    logic        csr_w, stall, redirect_valid;
    logic [1:0]  csr_wsc_mode;
    logic [31:0] mtvec_v = 32'h78;
    logic [31:0] mepc_v = 32'h104;

    typedef struct {
        string       tag;
        logic        w;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [1:0]  md;
        logic        st;
        logic        rv;
        logic [31:0] rpc;
        logic        crpc;
        logic [31:0] prd;
    } exp_t;
    exp_t q[$];
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign csr_rdata = (csr_raddr == 12'h305) ? mtvec_v :
                       (csr_raddr == 12'h341) ? mepc_v  : (32'hC0DE_0000 | {20'h0, csr_raddr});

    csr_trap_ctrl dut (
        .clk(clk), .rst(rst), .trap_req(trap_req), .trap_cause(trap_cause), .trap_epc(trap_epc),
        .trap_tval(trap_tval), .mret_req(mret_req), .pipe_csr_w(pipe_csr_w),
        .pipe_csr_waddr(pipe_csr_waddr), .pipe_csr_wdata(pipe_csr_wdata), .pipe_csr_mode(pipe_csr_mode),
        .pipe_csr_raddr(pipe_csr_raddr), .csr_rdata(csr_rdata), .mstatus(mstatus),
        .csr_raddr(csr_raddr), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_w(csr_w),
        .csr_wsc_mode(csr_wsc_mode), .pipe_csr_rdata(pipe_csr_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] ex);
        n_assert++;
        assert (obs === ex) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, ex);
        end
    endtask

    task automatic push(input string tag, input logic w, input logic [11:0] wa, input logic [31:0] wd,
                        input logic [1:0] md, input logic st, input logic rv, input logic [31:0] rpc,
                        input logic crpc, input logic [31:0] prd);
        exp_t e;
        e.tag = tag; e.w = w; e.wa = wa; e.wd = wd; e.md = md; e.st = st;
        e.rv = rv; e.rpc = rpc; e.crpc = crpc; e.prd = prd;
        q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = q.pop_front();
            chk(e.tag, "csr_w", {31'b0, csr_w}, {31'b0, e.w});
            if (e.w) begin
                chk(e.tag, "waddr", {20'b0, csr_waddr}, {20'b0, e.wa});
                chk(e.tag, "wdata", csr_wdata, e.wd);
                chk(e.tag, "mode", {30'b0, csr_wsc_mode}, {30'b0, e.md});
            end
            chk(e.tag, "stall", {31'b0, stall}, {31'b0, e.st});
            chk(e.tag, "rv", {31'b0, redirect_valid}, {31'b0, e.rv});
            if (e.crpc) chk(e.tag, "rpc", redirect_pc, e.rpc);
            chk(e.tag, "prd", pipe_csr_rdata, e.prd);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        pipe_csr_w = 1'b1;
        pipe_csr_waddr = 12'h341;
        push("rst_hold", 0, 0, 0, 0, 0, 0, 0, 1, 32'h78);
        cycle();
        rst = 1'b0;
        pipe_csr_w = 1'b0;
        push("reset_state", 0, 0, 0, 0, 0, 0, 0, 1, 32'h78);
        cycle();
        pipe_csr_w = 1'b1;
        pipe_csr_waddr = 12'h341;
        pipe_csr_wdata = 32'h1234;
        pipe_csr_mode = 2'b01;
        push("pass", 1, 12'h341, 32'h1234, 2'b01, 0, 0, 0, 0, 32'h78);
        cycle();
        pipe_csr_mode = 2'b10;
        pipe_csr_waddr = 12'h300;
        pipe_csr_raddr = 12'h341;
        push("pass_set", 1, 12'h300, 32'h1234, 2'b10, 0, 0, 0, 0, 32'h104);
        cycle();
        pipe_csr_w = 1'b0;
        pipe_csr_raddr = 12'h305;
        mstatus = 32'h88;
        trap_req = 1'b1;
        trap_cause = 32'h2;
        trap_epc = 32'h100;
        trap_tval = 32'hdead;
        push("trap_n", 0, 0, 0, 0, 1, 0, 0, 0, 32'h78);
        cycle();
        trap_req = 1'b0;
        push("trap_epc", 1, 12'h341, 32'h100, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        push("trap_cause", 1, 12'h342, 32'h2, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        push("trap_tval", 1, 12'h343, 32'hdead, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        push("trap_status", 1, 12'h300, 32'h80, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        push("trap_vec", 0, 0, 0, 0, 1, 1, 32'h78, 1, 0);
        cycle();
        push("trap_done", 0, 0, 0, 0, 0, 0, 0, 0, 32'h78);
        cycle();
        mstatus = 32'h80;
        mret_req = 1'b1;
        push("mret_n", 0, 0, 0, 0, 1, 0, 0, 0, 32'h78);
        cycle();
        mret_req = 1'b0;
        push("mret_status", 1, 12'h300, 32'h88, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        push("mret_epc", 0, 0, 0, 0, 1, 1, 32'h104, 1, 0);
        cycle();
        push("mret_done", 0, 0, 0, 0, 0, 0, 0, 0, 32'h78);
        cycle();
        mtvec_v = 32'h1003;
        mstatus = 32'h08;
        trap_req = 1'b1;
        mret_req = 1'b1;
        pipe_csr_w = 1'b1;
        pipe_csr_waddr = 12'h300;
        pipe_csr_wdata = 32'hffff;
        pipe_csr_mode = 2'b01;
        trap_cause = 32'hb;
        trap_epc = 32'h200;
        trap_tval = 32'h0;
        push("coll_n", 0, 0, 0, 0, 1, 0, 0, 0, 32'h1003);
        cycle();
        trap_req = 1'b0;
        mret_req = 1'b0;
        pipe_csr_w = 1'b0;
        push("coll_epc", 1, 12'h341, 32'h200, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        push("coll_cause", 1, 12'h342, 32'hb, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        push("coll_tval", 1, 12'h343, 32'h0, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        push("coll_status", 1, 12'h300, 32'h80, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        push("coll_vec", 0, 0, 0, 0, 1, 1, 32'h1000, 1, 0);
        cycle();
        push("coll_idle", 0, 0, 0, 0, 0, 0, 0, 0, 32'h1003);
        cycle();
        mtvec_v = 32'h78;
        mstatus = 32'hffff_fff7;
        trap_req = 1'b1;
        trap_cause = 32'h3;
        trap_epc = 32'h300;
        trap_tval = 32'h44;
        push("busy_n", 0, 0, 0, 0, 1, 0, 0, 0, 32'h78);
        cycle();
        trap_req = 1'b0;
        push("busy_epc", 1, 12'h341, 32'h300, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        trap_req = 1'b1;
        trap_cause = 32'h9;
        trap_epc = 32'h900;
        push("busy_cause", 1, 12'h342, 32'h3, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        trap_req = 1'b0;
        mret_req = 1'b1;
        push("busy_tval", 1, 12'h343, 32'h44, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        mret_req = 1'b0;
        push("busy_status", 1, 12'h300, 32'hffff_ff77, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        push("busy_vec", 0, 0, 0, 0, 1, 1, 32'h78, 1, 0);
        cycle();
        push("busy_idle1", 0, 0, 0, 0, 0, 0, 0, 0, 32'h78);
        cycle();
        push("busy_idle2", 0, 0, 0, 0, 0, 0, 0, 0, 32'h78);
        cycle();
        mstatus = 32'h88;
        trap_req = 1'b1;
        trap_cause = 32'h5;
        trap_epc = 32'h500;
        trap_tval = 32'h55;
        push("rst_n", 0, 0, 0, 0, 1, 0, 0, 0, 32'h78);
        cycle();
        trap_req = 1'b0;
        push("rst_epc", 1, 12'h341, 32'h500, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        push("rst_cause", 1, 12'h342, 32'h5, 2'b01, 1, 0, 0, 0, 0);
        cycle();
        rst = 1'b1;
        push("rst_abort", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle();
        rst = 1'b0;
        push("rst_after1", 0, 0, 0, 0, 0, 0, 0, 1, 32'h78);
        cycle();
        push("rst_after2", 0, 0, 0, 0, 0, 0, 0, 1, 32'h78);
        cycle();
        push("rst_after3", 0, 0, 0, 0, 0, 0, 0, 1, 32'h78);
        cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Sequencer that owns the single write port and single read port of the machine-mode CSR register file.
- Runs the trap-entry sequence: save mepc/mcause/mtval, update mstatus, read mtvec, redirect PC.
- Runs the mret sequence: restore mstatus, read mepc, redirect PC.
- Arbitrates the CSR ports between these sequences and pipeline CSR instructions, stalling the pipeline while a sequence is in progress.

Parameters:
- ADDR_MSTATUS, 12'h300, mstatus address
- ADDR_MTVEC, 12'h305, mtvec address
- ADDR_MEPC, 12'h341, mepc address
- ADDR_MCAUSE, 12'h342, mcause address
- ADDR_MTVAL, 12'h343, mtval address

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- trap_req  in  1  trap request pulse from pipeline
- trap_cause  in  32  mcause value
- trap_epc  in  32  faulting instruction PC
- trap_tval  in  32  mtval value
- mret_req  in  1  mret request pulse
- pipe_csr_w  in  1  pipeline CSR write enable
- pipe_csr_waddr  in  12  pipeline CSR write address
- pipe_csr_wdata  in  32  pipeline CSR write data
- pipe_csr_mode  in  2  01 write, 10 set, 11 clear
- pipe_csr_raddr  in  12  pipeline CSR read address
- csr_rdata  in  32  read data from CSR file
- mstatus  in  32  live mstatus from CSR file
- csr_raddr  out  12  to CSR file
- csr_waddr  out  12  to CSR file
- csr_wdata  out  32  to CSR file
- csr_w  out  1  to CSR file
- csr_wsc_mode  out  2  to CSR file
- pipe_csr_rdata  out  32  read data returned to pipeline
- stall  out  1  freeze pipeline
- redirect_valid  out  1  one-cycle PC redirect pulse
- redirect_pc  out  32  redirect target

Behaviour:
- FSM states: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_VEC, M_STATUS, M_EPC.
- Reset: state IDLE; latched cause/epc/tval cleared to 0; csr_w=0; redirect_valid=0; redirect_pc=0.
- Reset mid-sequence aborts it; no further CSR writes are issued.
- IDLE, no request:
  - CSR ports pass through combinationally from the pipe_* inputs.
  - pipe_csr_rdata = csr_rdata.
  - stall=0.
- IDLE, trap_req=1 (cycle N):
  - Latch cause/epc/tval.
  - stall=1 combinationally.
  - Pipeline write suppressed (csr_w=0).
  - Next state T_EPC.
- Trap sequence, one write per cycle, all with mode 01:
  - T_EPC (N+1): mepc <= epc.
  - T_CAUSE (N+2): mcause <= cause.
  - T_TVAL (N+3): mtval <= tval.
  - T_STATUS (N+4): mstatus <= mstatus with bit7 (MPIE) = old bit3 (MIE), bit3 = 0, other bits unchanged.
- T_VEC (N+5):
  - csr_raddr = mtvec, csr_w=0.
  - redirect_valid=1, redirect_pc = {csr_rdata[31:2], 2'b00} (direct mode only).
  - Next state IDLE.
- mret_req in IDLE (cycle N):
  - stall=1, pipeline write suppressed.
  - M_STATUS (N+1): mstatus bit3 = old bit7, bit7 = 1, mode 01.
  - M_EPC (N+2): csr_raddr = mepc; redirect_valid=1, redirect_pc = {csr_rdata[31:2], 2'b00}.
  - Next state IDLE.
- stall is high from the request cycle through the redirect cycle inclusive: trap N..N+5, mret N..N+2. It is low in every other cycle.
- trap_req and mret_req in the same cycle: trap wins; mret dropped.
- Requests are sampled only in IDLE; requests while busy are ignored. The pipeline cannot issue them because stall is high.
- pipe_csr_rdata is 0 whenever state is not IDLE.
- Per-field mstatus update uses mode 01 with a computed full word, never set/clear modes.
- redirect_valid is exactly one cycle per sequence.

Decomposition:
- Shared package holds:
  - CSR address constants.
  - CSR write-mode encodings (WSC_WRITE=2'b01, WSC_SET=2'b10, WSC_CLEAR=2'b11).
  - mstatus bit indices MIE=3, MPIE=7.
  - FSM state encoding.
- No sub-module; a single FSM plus a combinational port mux.

Test Plan:
- Pass-through: IDLE, pipe write 0x341 <- 0x1234 mode 01 -> csr_w=1, csr_waddr=0x341, csr_wdata=0x1234, stall=0.
- Trap sequence: mstatus=0x88, mtvec=0x78, trap_req with cause=2, epc=0x100, tval=0xdead.
  - Writes appear in cycles N+1..N+4: mepc=0x100, mcause=2, mtval=0xdead, mstatus=0x80.
  - N+5: redirect_valid=1, redirect_pc=0x78.
  - stall high N..N+5.
- mret: mstatus=0x80, mepc=0x104, mret_req -> N+1 mstatus write 0x88; N+2 redirect_pc=0x104; stall high N..N+2.
- Collision: trap_req, mret_req and pipe_csr_w all high in the same cycle -> trap sequence only; pipe write absent; no mret redirect.
- Busy: trap_req re-asserted at N+2 -> ignored; exactly one redirect, at N+5.
- Reset: rst asserted at N+3 of a trap -> next cycle state IDLE, csr_w=0, stall=0, redirect_valid=0; mtval and mstatus not written.
